// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding, alignment
// mask and the default timeout limit.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam logic [1:0] ALIGN_MASK      = 2'b11;
  localparam int         DEFAULT_TIMEOUT = 255;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter for an outstanding memory request; tc_o flags the last
// cycle the request may stay open.
module mem_timeout_counter #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      count <= '0;
    else if (clr_i)
      count <= '0;
    else if (en_i)
      count <= count + WIDTH'(1);
  end

  assign tc_o = (count == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over a req/ready handshake, stalls upstream
// while an access is open, aborts hung accesses and flags misaligned ones.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RDaddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] Data1_o,
  output logic [31:0] Data2_o,
  output logic [4:0]  RDaddr_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  mem_state_e  state;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic        mem_op, start, misalign, done, timeout, tc;

  assign mem_op   = valid_i & (MemRead_i | MemWrite_i);
  assign start    = (state == ST_IDLE) &  mem_op &  is_word_aligned(ALUResult_i);
  assign misalign = (state == ST_IDLE) &  mem_op & ~is_word_aligned(ALUResult_i);
  assign done     = (state == ST_REQ)  &  mem_ready_i;
  assign timeout  = (state == ST_REQ)  & ~mem_ready_i & tc;

  mem_timeout_counter #(
    .WIDTH (CNT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state != ST_REQ),
    .en_i  (state == ST_REQ),
    .tc_o  (tc)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (misalign || timeout)
        err_o <= 1'b1;
      else if (err_clr_i)
        err_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_REQ;
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= ALUResult_i;
            mem_wdata_o <= WriteData_i;
            fault_q     <= 1'b0;
          end
        end
        ST_REQ: begin
          if (done) begin
            rdata_q   <= mem_we_o ? '0 : mem_rdata_i;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            state     <= ST_RESP;
          end else if (timeout) begin
            rdata_q   <= '0;
            fault_q   <= 1'b1;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RESP re-reads the held EX/MEM inputs; only Data1 comes from the access.
  always_comb begin
    stall_o    = 1'b0;
    RegWrite_o = 1'b0;
    Data1_o    = '0;
    case (state)
      ST_IDLE: begin
        stall_o    = start;
        RegWrite_o = valid_i & RegWrite_i & ~mem_op;
      end
      ST_REQ:  stall_o = 1'b1;
      ST_RESP: begin
        Data1_o    = rdata_q;
        RegWrite_o = RegWrite_i & ~fault_q;
      end
      default: ;
    endcase
    if (!rst_i)
      stall_o = 1'b0;
  end

  assign Data2_o    = ALUResult_i;
  assign RDaddr_o   = RDaddr_i;
  assign MemtoReg_o = MemtoReg_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: pass-through vector table, directed memory
// transactions and randomized traffic against a transaction-level model.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
  logic [31:0] ALUResult_i, WriteData_i;
  logic [4:0]  RDaddr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0] Data1_o, Data2_o;
  logic [4:0]  RDaddr_o;
  logic        err_o, err_clr_i;

  int total = 0;
  int bad   = 0;
  logic err_m = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .ALUResult_i(ALUResult_i), .WriteData_i(WriteData_i), .RDaddr_i(RDaddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .Data1_o(Data1_o), .Data2_o(Data2_o), .RDaddr_o(RDaddr_o),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid_i = 0; MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; MemtoReg_i = 0;
    ALUResult_i = 0; WriteData_i = 0; RDaddr_i = 0; mem_ready_i = 0;
    mem_rdata_i = 0; err_clr_i = 0;
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store. waits >= TO means memory never answers.
  task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input logic rw,
                        input logic clr);
    logic memop, mis, tmo;
    logic [4:0] rd;
    int nreq;
    rd = 5'($urandom);
    @(negedge clk);
    valid_i = 1; MemRead_i = (kind == 1); MemWrite_i = (kind == 2);
    RegWrite_i = rw; MemtoReg_i = (kind == 1); ALUResult_i = addr;
    WriteData_i = wdata; RDaddr_i = rd; mem_ready_i = 0; err_clr_i = clr;
    #1;
    memop = (kind != 0);
    mis   = memop && (addr[1:0] != 2'b00);
    chk("data2", Data2_o, addr);
    chk("rdaddr", 32'(RDaddr_o), 32'(rd));
    chk("memtoreg", 32'(MemtoReg_o), 32'(kind == 1));
    chk("err_pre", 32'(err_o), 32'(err_m));
    chk("req_idle", 32'(mem_req_o), 0);
    if (!memop || mis) begin
      chk("stall_pass", 32'(stall_o), 0);
      chk("rw_pass", 32'(RegWrite_o), 32'(memop ? 1'b0 : rw));
      chk("data1_pass", Data1_o, 0);
      err_m = mis | (err_m & ~clr);
      return;
    end
    chk("stall_detect", 32'(stall_o), 1);
    chk("rw_detect", 32'(RegWrite_o), 0);
    err_m = err_m & ~clr;
    tmo  = (waits >= TO);
    nreq = tmo ? TO : waits + 1;
    for (int i = 0; i < nreq; i++) begin
      @(negedge clk);
      err_clr_i   = 0;
      mem_ready_i = (i == waits);
      mem_rdata_i = (i == waits) ? rdata : $urandom;
      #1;
      chk("req_on", 32'(mem_req_o), 1);
      chk("we", 32'(mem_we_o), 32'(kind == 2));
      chk("addr", mem_addr_o, addr);
      if (kind == 2) chk("wdata", mem_wdata_o, wdata);
      chk("stall_req", 32'(stall_o), 1);
      chk("rw_req", 32'(RegWrite_o), 0);
      chk("err_req", 32'(err_o), 32'(err_m));
    end
    if (tmo) err_m = 1'b1;
    @(negedge clk);
    mem_ready_i = 0;
    #1;
    chk("req_off", 32'(mem_req_o), 0);
    chk("we_off", 32'(mem_we_o), 0);
    chk("stall_resp", 32'(stall_o), 0);
    if (kind == 1 || tmo) chk("data1_resp", Data1_o, tmo ? 32'h0 : rdata);
    chk("rw_resp", 32'(RegWrite_o), 32'(tmo ? 1'b0 : rw));
    chk("err_resp", 32'(err_o), 32'(err_m));
  endtask

  typedef struct {
    logic        valid, mrd, mwr, rw;
    logic [31:0] alu;
    logic        e_rw;
    logic        e_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 0, 0, 1, 32'h0000_1234, 1, 0};
    vecs[1] = '{0, 0, 0, 1, 32'h0000_5678, 0, 0};
    vecs[2] = '{1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0};
    vecs[3] = '{0, 1, 0, 1, 32'h0000_0040, 0, 0};
    vecs[4] = '{1, 1, 0, 1, 32'h0000_0042, 0, 1};
    vecs[5] = '{1, 0, 1, 1, 32'h0000_0083, 0, 1};

    idle_inputs();
    rst_i = 0;
    #12;
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_data1", Data1_o, 0);
    @(negedge clk);
    rst_i = 1;

    // Pass-through and misaligned cases: no request ever leaves IDLE.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_i = vecs[i].valid; MemRead_i = vecs[i].mrd; MemWrite_i = vecs[i].mwr;
      RegWrite_i = vecs[i].rw; ALUResult_i = vecs[i].alu; err_clr_i = 0;
      #1;
      chk("tbl_stall", 32'(stall_o), 0);
      chk("tbl_rw", 32'(RegWrite_o), 32'(vecs[i].e_rw));
      chk("tbl_data1", Data1_o, 0);
      chk("tbl_data2", Data2_o, vecs[i].alu);
      chk("tbl_req", 32'(mem_req_o), 0);
      chk("tbl_err", 32'(err_o), 32'(err_m));
      err_m = err_m | vecs[i].e_err;
    end
    @(negedge clk);
    idle_inputs();
    err_clr_i = 1;
    #1;
    chk("err_sticky", 32'(err_o), 1);
    @(negedge clk);
    err_clr_i = 0;
    #1;
    chk("err_cleared", 32'(err_o), 0);
    err_m = 0;

    run_op(0, 32'h0000_1234, 0, 0, 0, 1, 0);
    run_op(1, 32'h0000_0040, 0, 32'hDEAD_BEEF, 2, 1, 0);
    run_op(2, 32'h0000_0080, 32'hCAFE_F00D, 0, 0, 1, 0);
    run_op(1, 32'h0000_0042, 0, 0, 0, 1, 0);
    run_op(0, 32'h0000_0010, 0, 0, 0, 0, 1);
    run_op(1, 32'h0000_0044, 0, 32'h1111_2222, 9, 1, 0);
    run_op(1, 32'h0000_0041, 0, 0, 0, 1, 1);
    run_op(2, 32'h0000_0088, 32'h5555_AAAA, 0, 3, 1, 0);
    run_op(1, 32'h0000_008C, 0, 32'h0BAD_F00D, 0, 1, 0);

    // Asynchronous reset while a request is open.
    @(negedge clk);
    valid_i = 1; MemRead_i = 1; MemWrite_i = 0; RegWrite_i = 1; MemtoReg_i = 1;
    ALUResult_i = 32'h0000_0100; mem_ready_i = 0; err_clr_i = 0;
    @(negedge clk);
    #1;
    chk("mid_req_on", 32'(mem_req_o), 1);
    #2;
    rst_i = 0;
    #1;
    chk("mid_rst_req", 32'(mem_req_o), 0);
    chk("mid_rst_stall", 32'(stall_o), 0);
    chk("mid_rst_err", 32'(err_o), 0);
    chk("mid_rst_rw", 32'(RegWrite_o), 0);
    err_m = 0;
    @(negedge clk);
    idle_inputs();
    rst_i = 1;
    run_op(1, 32'h0000_0100, 0, 32'h7777_8888, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 3);
      a = {$urandom} & 32'h0000_FFFC;
      if (k == 3) begin
        a = a | 32'($urandom_range(1, 3));
        k = $urandom_range(1, 2);
      end
      run_op(k, a, $urandom, $urandom, $urandom_range(0, 5), 1'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    idle_inputs();
    #1;
    chk("final_stall", 32'(stall_o), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. Takes the registered EX results, performs the load/store against a variable-latency data memory over a req/ready handshake, and presents the write-back bundle to the MEM/WB register. Stalls the upstream pipeline while an access is outstanding, aborts hung accesses on timeout, and rejects misaligned word accesses.

## Interface
- TIMEOUT_CYCLES, 255: max REQ-state cycles before abort (1..65535)
- CNT_WIDTH, 16: timeout counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  EX/MEM holds a valid instruction
- MemRead_i, MemWrite_i  in  1 each  load / store request (never both)
- RegWrite_i, MemtoReg_i  in  1 each  write-back controls
- ALUResult_i  in  32  ALU result; byte address for loads/stores
- WriteData_i  in  32  store data
- RDaddr_i  in  5  destination register
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o, mem_wdata_o  out  32 each  address, store data
- mem_ready_i  in  1  memory accepts/completes the current request
- mem_rdata_i  in  32  load data, valid with mem_ready_i
- stall_o  out  1  upstream must hold EX/MEM contents
- RegWrite_o, MemtoReg_o  out  1 each  to MEM/WB
- Data1_o  out  32  load data to MEM/WB
- Data2_o  out  32  ALU result to MEM/WB
- RDaddr_o  out  5  to MEM/WB
- err_o  out  1  sticky fault flag
- err_clr_i  in  1  clears err_o

## Operation
- States: IDLE, REQ, RESP.
- IDLE, no memory op (valid_i=0 or MemRead_i=MemWrite_i=0): pure pass-through; stall_o=0; Data1_o=0; RegWrite_o=valid_i&RegWrite_i.
- IDLE, memory op, ALUResult_i[1:0]==0: stall_o=1, RegWrite_o=0 (bubble); next state REQ; latch addr, wdata, we.
- IDLE, memory op, misaligned: no request; err_o set; pass-through with RegWrite_o=0; stall_o=0.
- REQ: mem_req_o=1, address/data/we held constant; stall_o=1; RegWrite_o=0. Counter increments each cycle.
  - mem_ready_i=1: capture mem_rdata_i (loads) into the read-data register; go RESP.
  - counter reaches TIMEOUT_CYCLES-1 without ready: drop request, read-data register=0, set err_o, mark fault; go RESP.
- RESP: stall_o=0; Data1_o=read-data register; Data2_o=ALUResult_i; RegWrite_o=RegWrite_i unless faulted (then 0); go IDLE.
- Data2_o, RDaddr_o, MemtoReg_o always follow inputs combinationally.
- err_o: sticky; set dominates err_clr_i in the same cycle.
- Reset: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, counter=0, read-data register=0, fault=0, err_o=0; combinational outputs follow from these with inputs.

## Timing
- Minimum load/store occupancy: 3 cycles (IDLE-detect, REQ with same-cycle ready, RESP). N ready-wait cycles add N.
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o are registered: asserted the cycle after detection, deasserted the cycle after ready is sampled.
- Upstream holds inputs stable whenever stall_o=1; block relies on this and re-reads inputs in RESP.
- Exactly one RegWrite_o=1 pulse per instruction; MEM/WB captures bubbles while stalled.
- Reset mid-REQ: request dropped immediately (async), no write-back for the in-flight instruction.
- Back-to-back memory ops: RESP→IDLE→REQ, no overlap; never two requests outstanding.

## Structure
- Package mem_stage_pkg: state encoding (IDLE/REQ/RESP), ALIGN_MASK=2'b11, default TIMEOUT_CYCLES.
- One sub-module: mem_timeout_counter (clear, enable, terminal-count output, parameterised width and limit).
- Rest stays in one FSM plus registered request block.

## Test plan
- ALU op, valid_i=1, RegWrite_i=1, ALUResult_i=0x1234 -> same cycle stall_o=0, RegWrite_o=1, Data2_o=0x1234, no mem_req_o.
- Load addr 0x40, ready after 2 wait cycles, rdata 0xDEADBEEF -> stall_o high 4 cycles, mem_req_o high 3 cycles, RESP: Data1_o=0xDEADBEEF, RegWrite_o=1 for one cycle.
- Store addr 0x80, WriteData_i=0xCAFEF00D, same-cycle ready -> mem_we_o=1, mem_wdata_o=0xCAFEF00D for 1 cycle; 3-cycle occupancy.
- Load addr 0x42 -> no request, err_o=1, RegWrite_o=0; err_clr_i pulse -> err_o=0.
- TIMEOUT_CYCLES=4, mem_ready_i held 0 -> mem_req_o drops after 4 cycles, err_o=1, RESP Data1_o=0, RegWrite_o=0.
- rst_i low during REQ -> mem_req_o=0 and stall_o=0 immediately; after release a fresh load completes normally.
